// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, the imem request/ready handshake and the IF/ID register.
// Optional perf counters (wait_cycles, kill_count) are built when IF_FETCH_PERF_EN is defined.
module if_fetch_ctrl #(
  parameter int unsigned  W        = 32,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         branch,
  input  logic [W-1:0] pc_branch,
  input  logic         stall_d,
  input  logic         flush_d,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [W-1:0] imem_rdata,
  output logic [W-1:0] pc,
  output logic [W-1:0] Instruction_D,
  output logic [W-1:0] PcPlus4_D,
  output logic         valid_D
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [W-1:0] wait_cycles,
  output logic [W-1:0] kill_count
`endif
);

  typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

  localparam logic [W-1:0] Four = W'(4);

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic         kill_q, kill_d;
  logic [W-1:0] hold_q, hold_d;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;
  logic         accept;
  logic         load;
  logic [W-1:0] load_word;
  logic [W-1:0] pc_plus4;

  assign accept   = req_q & imem_ready;
  assign pc_plus4 = pc_q + Four;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    kill_d    = kill_q;
    hold_d    = hold_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    load      = 1'b0;
    load_word = imem_rdata;
    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
        if (branch) pc_d = pc_branch;
      end
      StFetch: begin
        if (accept) begin
          if (branch) begin
            pc_d   = pc_branch;
            kill_d = 1'b0;
          end else if (kill_q) begin
            pc_d   = tgt_q;
            kill_d = 1'b0;
          end else if (!stall_d) begin
            load = 1'b1;
            pc_d = pc_plus4;
          end else begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end
        end else if (branch) begin
          // Address must stay stable under the outstanding request; redirect after it returns.
          tgt_d  = pc_branch;
          kill_d = 1'b1;
        end
      end
      StHold: begin
        if (branch) begin
          pc_d    = pc_branch;
          state_d = StFetch;
        end else if (!stall_d) begin
          load      = 1'b1;
          load_word = hold_q;
          pc_d      = pc_plus4;
          state_d   = StFetch;
        end
      end
      default: state_d = StBoot;
    endcase

    if (load) begin
      instr_d = load_word;
      pc4_d   = pc_plus4;
    end
    // ID consumes its instruction whenever it is not stalled; bubble if nothing new arrives.
    if (load)          valid_d = ~flush_d;
    else if (!stall_d) valid_d = 1'b0;
    else               valid_d = valid_q;
    if (flush_d || branch) valid_d = 1'b0;

    req_d = (state_d == StFetch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      kill_q  <= 1'b0;
      hold_q  <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign Instruction_D = instr_q;
  assign PcPlus4_D     = pc4_q;
  assign valid_D       = valid_q;

`ifdef IF_FETCH_PERF_EN
  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] wait_q, wait_d;
  logic [W-1:0] kcnt_q, kcnt_d;
  logic         discard;

  assign discard = accept && (state_q == StFetch) && (branch || kill_q);

  always_comb begin
    wait_d = wait_q;
    kcnt_d = kcnt_q;
    if (req_q && !imem_ready && (wait_q != '1)) wait_d = wait_q + One;
    if (discard && (kcnt_q != '1))             kcnt_d = kcnt_q + One;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      kcnt_q <= '0;
    end else begin
      wait_q <= wait_d;
      kcnt_q <= kcnt_d;
    end
  end

  assign wait_cycles = wait_q;
  assign kill_count  = kcnt_q;
`endif

endmodule
